stg_rt: RTL and testbench

Retire-side sequence collector for the amber pipeline. It consumes the micro-op stream emitted by the translate stage after it has flowed through execution, with first/last sequence markers. It collapses each multi-micro-op expansion (JSR/BSR/RET/PUSH/POP) back into a single architectural retirement event carrying the original PC and micro-op count. It also provides the interrupt-safe window and protocol-violation detection for the expansion protocol.

---
 rtl/stg_rt_pkg.sv | 14 +
 rtl/stg_rt.sv | 138 +++++++++++++
 tb/tb_stg_rt.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/stg_rt_pkg.sv
// Shared sizing and state encodings for the amber retire-side sequence collector.
package stg_rt_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int LEN_W       = 3;
    localparam int MAX_SEQ_DEF = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEQ  = 1'b1
    } state_t;

endpackage

// File: rtl/stg_rt.sv
// Collapses first/last-marked micro-op expansions into one registered retire event; latency 1.
// No backpressure: iw_stall freezes all state and outputs, iw_flush drops any partial sequence.
module stg_rt
    import stg_rt_pkg::*;
#(
    parameter int MAX_SEQ = MAX_SEQ_DEF,
    parameter int CNT_W   = 32
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_uop_valid,
    input  logic              iw_uop_first,
    input  logic              iw_uop_last,
    input  logic [ADDR_W-1:0] iw_pc,
    input  logic [DATA_W-1:0] iw_instr,
    input  logic              iw_flush,
    input  logic              iw_stall,
    output logic              ow_ret_valid,
    output logic [ADDR_W-1:0] ow_ret_pc,
    output logic [LEN_W-1:0]  ow_ret_len,
    output logic [DATA_W-1:0] ow_ret_instr,
    output logic              ow_int_ok,
    output logic              ow_seq_err,
    output logic [CNT_W-1:0]  ow_ret_cnt
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_hold_q, pc_hold_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ret_valid_q, ret_valid_d;
    logic [ADDR_W-1:0]   ret_pc_q, ret_pc_d;
    logic [LEN_W-1:0]    ret_len_q, ret_len_d;
    logic [DATA_W-1:0]   ret_instr_q, ret_instr_d;
    logic                seq_err_q, seq_err_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic                start_new;
    logic [LEN_W-1:0]    len_inc;

    assign len_inc = len_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_hold_d   = pc_hold_q;
        len_d       = len_q;
        ret_valid_d = ret_valid_q;
        ret_pc_d    = ret_pc_q;
        ret_len_d   = ret_len_q;
        ret_instr_d = ret_instr_q;
        seq_err_d   = seq_err_q;
        ret_cnt_d   = ret_cnt_q;
        start_new   = 1'b0;

        if (iw_flush) begin
            state_d     = S_IDLE;
            len_d       = '0;
            ret_valid_d = 1'b0;
        end else if (!iw_stall) begin
            ret_valid_d = 1'b0;
            if (iw_uop_valid) begin
                if (state_q == S_IDLE) begin
                    if (iw_uop_first) start_new = 1'b1;
                    else              seq_err_d = 1'b1;
                end else if (iw_uop_first) begin
                    // Abandon the partial sequence, then handle the new op as if idle.
                    seq_err_d = 1'b1;
                    state_d   = S_IDLE;
                    len_d     = '0;
                    start_new = 1'b1;
                end else if (iw_pc != pc_hold_q) begin
                    seq_err_d = 1'b1;
                    state_d   = S_IDLE;
                    len_d     = '0;
                end else if (iw_uop_last) begin
                    ret_valid_d = 1'b1;
                    ret_pc_d    = pc_hold_q;
                    ret_len_d   = len_inc;
                    ret_instr_d = iw_instr;
                    ret_cnt_d   = ret_cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                    len_d       = '0;
                end else if (len_inc == LEN_W'(MAX_SEQ)) begin
                    seq_err_d = 1'b1;
                    state_d   = S_IDLE;
                    len_d     = '0;
                end else begin
                    len_d = len_inc;
                end

                if (start_new) begin
                    if (iw_uop_last) begin
                        ret_valid_d = 1'b1;
                        ret_pc_d    = iw_pc;
                        ret_len_d   = LEN_W'(1);
                        ret_instr_d = iw_instr;
                        ret_cnt_d   = ret_cnt_q + CNT_W'(1);
                    end else begin
                        pc_hold_d = iw_pc;
                        len_d     = LEN_W'(1);
                        state_d   = S_SEQ;
                    end
                end
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q     <= S_IDLE;
            pc_hold_q   <= '0;
            len_q       <= '0;
            ret_valid_q <= 1'b0;
            ret_pc_q    <= '0;
            ret_len_q   <= '0;
            ret_instr_q <= '0;
            seq_err_q   <= 1'b0;
            ret_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_hold_q   <= pc_hold_d;
            len_q       <= len_d;
            ret_valid_q <= ret_valid_d;
            ret_pc_q    <= ret_pc_d;
            ret_len_q   <= ret_len_d;
            ret_instr_q <= ret_instr_d;
            seq_err_q   <= seq_err_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign ow_ret_valid = ret_valid_q;
    assign ow_ret_pc    = ret_pc_q;
    assign ow_ret_len   = ret_len_q;
    assign ow_ret_instr = ret_instr_q;
    assign ow_seq_err   = seq_err_q;
    assign ow_ret_cnt   = ret_cnt_q;
    assign ow_int_ok    = (state_q == S_IDLE);

endmodule

// File: tb/tb_stg_rt.sv
// Directed bench for stg_rt: expected retirements queued at issue, checked by a negedge monitor.
module tb_stg_rt;
    import stg_rt_pkg::*;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] instr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uop_valid = 1'b0;
    logic              uop_first = 1'b0;
    logic              uop_last  = 1'b0;
    logic [ADDR_W-1:0] pc        = '0;
    logic [DATA_W-1:0] instr     = '0;
    logic              flush     = 1'b0;
    logic              stall     = 1'b0;
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_pc;
    logic [LEN_W-1:0]  ret_len;
    logic [DATA_W-1:0] ret_instr;
    logic              int_ok;
    logic              seq_err;
    logic [CNT_W-1:0]  ret_cnt;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    bit   held = 1'b0;
    exp_t sb[$];

    stg_rt #(.MAX_SEQ(4), .CNT_W(CNT_W)) dut (
        .iw_clk(clk), .iw_rst(rst),
        .iw_uop_valid(uop_valid), .iw_uop_first(uop_first), .iw_uop_last(uop_last),
        .iw_pc(pc), .iw_instr(instr), .iw_flush(flush), .iw_stall(stall),
        .ow_ret_valid(ret_valid), .ow_ret_pc(ret_pc), .ow_ret_len(ret_len),
        .ow_ret_instr(ret_instr), .ow_int_ok(int_ok), .ow_seq_err(seq_err),
        .ow_ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A stalled pulse is the same retirement, so it is consumed only once.
    always @(negedge clk) begin
        if (ret_valid && !held) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", 64'(ret_pc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                exp_cnt++;
                check("ret_pc", 64'(ret_pc), 64'(e.pc));
                check("ret_len", 64'(ret_len), 64'(e.len));
                check("ret_instr", 64'(ret_instr), 64'(e.instr));
                check("ret_cnt", 64'(ret_cnt), 64'(exp_cnt));
            end
        end
        held = ret_valid && stall && !flush && !rst;
    end

    // Caller sits at posedge+1; returns at the next posedge+1 with outputs updated.
    task automatic cyc(input logic v, input logic f, input logic l, input logic [ADDR_W-1:0] p,
                       input logic [DATA_W-1:0] ins, input logic fl, input logic st);
        uop_valid = v; uop_first = f; uop_last = l; pc = p; instr = ins;
        flush = fl; stall = st;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic expect_ret(input logic [ADDR_W-1:0] p, input logic [LEN_W-1:0] n,
                              input logic [DATA_W-1:0] ins);
        exp_t e;
        e.pc = p; e.len = n; e.instr = ins;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        check("queue_drained_before_reset", 64'(sb.size()), 64'd0);
        sb.delete();
        rst = 1'b1;
        uop_valid = 1'b0; uop_first = 1'b0; uop_last = 1'b0; flush = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ret_valid", 64'(ret_valid), 64'd0);
        check("rst_ret_pc", 64'(ret_pc), 64'd0);
        check("rst_ret_len", 64'(ret_len), 64'd0);
        check("rst_ret_instr", 64'(ret_instr), 64'd0);
        check("rst_seq_err", 64'(seq_err), 64'd0);
        check("rst_ret_cnt", 64'(ret_cnt), 64'd0);
        check("rst_int_ok", 64'(int_ok), 64'd1);
        rst = 1'b0;

        // Pass-through
        expect_ret(16'h0100, 3'd1, 32'hA000_0001);
        cyc(1, 1, 1, 16'h0100, 32'hA000_0001, 0, 0);
        check("pass_int_ok", 64'(int_ok), 64'd1);
        check("pass_valid", 64'(ret_valid), 64'd1);
        idle();
        check("pass_pulse_drop", 64'(ret_valid), 64'd0);
        check("pass_hold_pc", 64'(ret_pc), 64'h0100);

        // JSR expansion, 4 uops
        cyc(1, 1, 0, 16'h0200, 32'hB000_0000, 0, 0);
        check("jsr_int_ok_0", 64'(int_ok), 64'd0);
        cyc(1, 0, 0, 16'h0200, 32'hB000_0001, 0, 0);
        check("jsr_int_ok_1", 64'(int_ok), 64'd0);
        cyc(1, 0, 0, 16'h0200, 32'hB000_0002, 0, 0);
        check("jsr_int_ok_2", 64'(int_ok), 64'd0);
        check("jsr_no_early_ret", 64'(ret_valid), 64'd0);
        expect_ret(16'h0200, 3'd4, 32'hB000_0003);
        cyc(1, 0, 1, 16'h0200, 32'hB000_0003, 0, 0);
        check("jsr_int_ok_end", 64'(int_ok), 64'd1);
        check("jsr_seq_err", 64'(seq_err), 64'd0);
        idle();

        // Flush mid-sequence, then a normal pass-through
        cyc(1, 1, 0, 16'h0300, 32'hC000_0000, 0, 0);
        cyc(1, 0, 0, 16'h0300, 32'hC000_0001, 0, 0);
        cyc(0, 0, 0, 16'h0000, 32'h0, 1, 0);
        check("flush_int_ok", 64'(int_ok), 64'd1);
        check("flush_seq_err", 64'(seq_err), 64'd0);
        check("flush_no_ret", 64'(ret_valid), 64'd0);
        expect_ret(16'h0310, 3'd1, 32'hC000_0010);
        cyc(1, 1, 1, 16'h0310, 32'hC000_0010, 0, 0);
        check("flush_after_cnt", 64'(ret_cnt), 64'd3);

        // Stall while a pulse is in flight; presented uops are ignored
        expect_ret(16'h0400, 3'd1, 32'hD000_0000);
        cyc(1, 1, 1, 16'h0400, 32'hD000_0000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 16'h0999, 32'hDEAD_BEEF, 0, 1);
            check("stall_valid_held", 64'(ret_valid), 64'd1);
            check("stall_cnt_held", 64'(ret_cnt), 64'd4);
            check("stall_pc_held", 64'(ret_pc), 64'h0400);
        end
        idle();
        check("stall_release_drop", 64'(ret_valid), 64'd0);
        check("stall_release_cnt", 64'(ret_cnt), 64'd4);

        // first=0 while idle
        cyc(1, 0, 1, 16'h0500, 32'hE000_0000, 0, 0);
        check("orphan_seq_err", 64'(seq_err), 64'd1);
        check("orphan_no_ret", 64'(ret_valid), 64'd0);
        check("orphan_int_ok", 64'(int_ok), 64'd1);
        idle();
        check("orphan_err_sticky", 64'(seq_err), 64'd1);

        // New first=1,last=1 mid-sequence: error and the new op retires
        do_reset();
        cyc(1, 1, 0, 16'h0600, 32'hF000_0000, 0, 0);
        cyc(1, 0, 0, 16'h0600, 32'hF000_0001, 0, 0);
        expect_ret(16'h0610, 3'd1, 32'hF000_0010);
        cyc(1, 1, 1, 16'h0610, 32'hF000_0010, 0, 0);
        check("restart_seq_err", 64'(seq_err), 64'd1);
        check("restart_int_ok", 64'(int_ok), 64'd1);
        idle();

        // Overlong: four uops without last
        do_reset();
        cyc(1, 1, 0, 16'h0700, 32'h7000_0000, 0, 0);
        cyc(1, 0, 0, 16'h0700, 32'h7000_0001, 0, 0);
        cyc(1, 0, 0, 16'h0700, 32'h7000_0002, 0, 0);
        check("overlong_err_before", 64'(seq_err), 64'd0);
        check("overlong_busy", 64'(int_ok), 64'd0);
        cyc(1, 0, 0, 16'h0700, 32'h7000_0003, 0, 0);
        check("overlong_seq_err", 64'(seq_err), 64'd1);
        check("overlong_idle", 64'(int_ok), 64'd1);
        check("overlong_no_ret", 64'(ret_valid), 64'd0);

        // Asynchronous reset clears a partial sequence without a clock edge
        do_reset();
        cyc(1, 1, 0, 16'h0800, 32'h8000_0000, 0, 0);
        check("async_pre_busy", 64'(int_ok), 64'd0);
        #2 rst = 1'b1;
        #1 check("async_rst_int_ok", 64'(int_ok), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // PC mismatch on the second uop
        cyc(1, 1, 0, 16'h0800, 32'h8000_0000, 0, 0);
        cyc(1, 0, 1, 16'h0801, 32'h8000_0001, 0, 0);
        check("pcmis_seq_err", 64'(seq_err), 64'd1);
        check("pcmis_no_ret", 64'(ret_valid), 64'd0);
        check("pcmis_int_ok", 64'(int_ok), 64'd1);

        // Back-to-back retirements with no bubble
        do_reset();
        cyc(1, 1, 0, 16'h0900, 32'h9000_0000, 0, 0);
        expect_ret(16'h0900, 3'd2, 32'h9000_0001);
        cyc(1, 0, 1, 16'h0900, 32'h9000_0001, 0, 0);
        expect_ret(16'h0910, 3'd1, 32'h9000_0010);
        cyc(1, 1, 1, 16'h0910, 32'h9000_0010, 0, 0);
        check("b2b_second_valid", 64'(ret_valid), 64'd1);
        check("b2b_cnt", 64'(ret_cnt), 64'd2);
        check("b2b_seq_err", 64'(seq_err), 64'd0);
        idle();
        idle();

        check("queue_drained_end", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
